// File: rtl/dlx_fetch_pkg.sv
// Shared types and constants for the DLX instruction-fetch slice.
// Holds the fetch FSM state encoding, buffer entry layout and PC helpers.
package dlx_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: redirect input, instruction-memory port and decode handshake.
// The master modport is the fetch unit, the slave modport its environment.
interface pc_fetch_if;
  import dlx_fetch_pkg::*;

  logic               take_branch;
  logic [ADDR_W-1:0]  target_pc;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_ready;

  modport master (
    input  take_branch,
    input  target_pc,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    output take_branch,
    output target_pc,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {instr, pc} entries between fetch and decode.
// Flush has priority over push and pop; push and pop may coincide at any occupancy.
module fetch_buffer
  import dlx_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop_i && !flush_i && (count_q != '0);
    do_push  = push_i && !flush_i && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head is masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: single-outstanding request FSM, fetch PC and redirect
// handling, feeding decode through a fetch_buffer.
module pc_fetch
  import dlx_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int                BUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_fetch_if.master bus
);

  localparam int             CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_BUSY  = BUSY;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              buf_push;
  logic              buf_pop;
  logic              buf_flush;
  logic              buf_valid;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W:0]    occ_now;
  logic [CNT_W:0]    occ_after;
  logic [ADDR_W-1:0] redirect_pc;

  assign redirect_pc = align_pc(bus.target_pc);
  assign buf_flush   = bus.take_branch;
  assign buf_pop     = buf_valid && bus.if_ready && !bus.take_branch;
  assign occ_now     = {1'b0, buf_count};
  assign occ_after   = occ_now + (CNT_W + 1)'(1) - (CNT_W + 1)'(buf_pop);

  assign push_entry.instr = bus.imem_rdata;
  assign push_entry.pc    = pc_q;

  // pc_q doubles as the request address: it only moves in IDLE or on an ack,
  // so imem_addr stays put for the whole life of a request.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    buf_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.take_branch) begin
          pc_d    = redirect_pc;
          state_d = S_BUSY;
        end else if (occ_now < DEPTH_C) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.imem_ack) begin
          if (bus.take_branch) begin
            pc_d = redirect_pc;
          end else begin
            buf_push = 1'b1;
            pc_d     = next_pc(pc_q);
            state_d  = (occ_after < DEPTH_C) ? S_BUSY : S_IDLE;
          end
        end else if (bus.take_branch) begin
          tgt_d   = redirect_pc;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.take_branch) begin
          tgt_d = redirect_pc;
        end
        if (bus.imem_ack) begin
          pc_d    = bus.take_branch ? redirect_pc : tgt_q;
          state_d = S_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (buf_push),
    .push_entry_i (push_entry),
    .pop_i        (buf_pop),
    .flush_i      (buf_flush),
    .valid_o      (buf_valid),
    .head_o       (head_entry),
    .count_o      (buf_count)
  );

  assign bus.imem_req  = (state_q == S_BUSY) || (state_q == S_DRAIN);
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = buf_valid;
  assign bus.if_instr  = head_entry.instr;
  assign bus.if_pc     = head_entry.pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: memory responses driven step by step, accepted
// instructions tracked in a scoreboard queue and compared as decode pops them.
module tb_pc_fetch;
  import dlx_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_entry_t sb[$];

  pc_fetch_if bus();

  pc_fetch #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode side: a pop happens at the coming edge, so compare the head first.
  task automatic tick();
    fetch_entry_t e;
    if (rst_n && bus.if_valid === 1'b1 && bus.if_ready && !bus.take_branch) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", bus.if_pc, e.pc);
        chk("pop_instr", bus.if_instr, e.instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    chk({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  task automatic step(input bit ack, input logic [31:0] exp_addr, input bit keep,
                      input bit br, input logic [31:0] tgt);
    fetch_entry_t e;
    if (ack) expect_req("ack", exp_addr);
    bus.imem_ack    = ack;
    bus.imem_rdata  = ack ? mem_word(exp_addr) : 32'h0;
    bus.take_branch = br;
    bus.target_pc   = tgt;
    if (ack && keep && !br) begin
      e.instr = mem_word(exp_addr);
      e.pc    = exp_addr;
      sb.push_back(e);
    end
    tick();
    if (br) sb.delete();
    bus.imem_ack    = 1'b0;
    bus.take_branch = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.take_branch = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    tick();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.take_branch = 1'b0;
    bus.target_pc   = 32'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.if_ready    = 1'b1;
    #1;
    chk("por_req", 32'(bus.imem_req), 32'd0);
    chk("por_addr", bus.imem_addr, RST_PC);
    chk("por_valid", 32'(bus.if_valid), 32'd0);
    chk("por_instr", bus.if_instr, 32'h0);
    chk("por_pc", bus.if_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Streaming with decode always ready.
    expect_req("first", RST_PC);
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("lat_valid", 32'(bus.if_valid), 32'd1);
    chk("lat_pc", bus.if_pc, 32'h0);
    step(1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 32'h0);
    chk("follow_pc", bus.if_pc, 32'hC);
    tick();
    chk("stream_empty", 32'(bus.if_valid), 32'd0);

    // Decode stalled: buffer fills and requests stop.
    do_reset();
    bus.if_ready = 1'b0;
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
    chk("stall_drop", 32'(bus.imem_req), 32'd0);
    tick();
    tick();
    chk("stall_req", 32'(bus.imem_req), 32'd0);
    chk("stall_valid", 32'(bus.if_valid), 32'd1);
    chk("stall_pc", bus.if_pc, 32'h0);
    chk("stall_instr", bus.if_instr, mem_word(32'h0));
    bus.if_ready = 1'b1;
    tick();
    tick();
    expect_req("resume", 32'h8);

    // Redirect while the request to 8 is still waiting for its ack.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    expect_req("drain_hold1", 32'h8);
    tick();
    expect_req("drain_hold2", 32'h8);
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    expect_req("redir_100", 32'h100);
    chk("drain_no_push", 32'(bus.if_valid), 32'd0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    chk("tgt_pc", bus.if_pc, 32'h100);

    // Redirect coincident with ack, then two redirects during DRAIN.
    step(1'b1, 32'h104, 1'b0, 1'b1, 32'h200);
    expect_req("coinc_200", 32'h200);
    chk("coinc_flush", 32'(bus.if_valid), 32'd0);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
    expect_req("drain2_hold", 32'h200);
    step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    expect_req("last_wins", 32'h400);
    step(1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
    tick();

    // Address wrap at the top of memory and target alignment.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 32'h404, 1'b0, 1'b0, 32'h0);
    expect_req("wrap_req", 32'hFFFF_FFFC);
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    expect_req("wrap_zero", 32'h0);
    chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    step(1'b1, 32'h0, 1'b0, 1'b1, 32'h103);
    expect_req("align_100", 32'h100);

    // Asynchronous reset mid-request; the late ack must be ignored.
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_addr", bus.imem_addr, RST_PC);
    chk("arst_valid", 32'(bus.if_valid), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mem_word(32'h100);
    tick();
    rst_n = 1'b1;
    sb.delete();
    tick();
    bus.imem_ack = 1'b0;
    chk("late_ack_valid", 32'(bus.if_valid), 32'd0);
    expect_req("restart", RST_PC);
    step(1'b1, RST_PC, 1'b1, 1'b0, 32'h0);
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of first instruction fetched after reset.
REQ-002 Parameter BUF_DEPTH, default 2, entries in the fetch buffer toward decode (legal range 2..4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 take_branch  input  1  redirect request from jump/branch resolution, one-cycle pulse per redirect.
REQ-006 target_pc  input  32  redirect target, sampled when take_branch=1.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word address of the request, bits [1:0] always 0.
REQ-009 imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_valid  output  1  buffer head holds a valid instruction for decode.
REQ-012 if_instr  output  32  instruction at buffer head.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 if_ready  input  1  decode accepts head; pop when if_valid && if_ready.

Function
REQ-015 State machine states: IDLE (nothing outstanding), BUSY (valid request outstanding), DRAIN (stale request outstanding, response to be discarded).
REQ-016 At most one request outstanding; imem_req=1 exactly in BUSY and DRAIN; imem_addr constant from assertion through the ack cycle.
REQ-017 imem_ack while imem_req=0 is ignored.
REQ-018 IDLE->BUSY when occupancy < BUF_DEPTH; imem_addr = fetch PC.
REQ-019 BUSY with ack, no redirect: push {imem_rdata, imem_addr}, fetch PC <= imem_addr+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); stay BUSY with new address next cycle if occupancy after push/pop < BUF_DEPTH, else IDLE.
REQ-020 Issue check counts the outstanding request: request issued only if occupancy + outstanding < BUF_DEPTH, so a push never hits a full buffer.
REQ-021 Simultaneous push and pop permitted in every occupancy, including full.
REQ-022 take_branch=1: all buffer entries discarded at that edge (if_valid=0 next cycle); fetch PC <= {target_pc[31:2],2'b00}.
REQ-023 take_branch in IDLE: next cycle BUSY with imem_addr = target.
REQ-024 take_branch in BUSY without ack: -> DRAIN; imem_req held with old address until ack; response discarded; then BUSY at target.
REQ-025 take_branch in BUSY with ack same cycle: response discarded, next cycle BUSY at target (no DRAIN).
REQ-026 take_branch in DRAIN: target replaced by newest target_pc; last one wins.
REQ-027 take_branch coinciding with a pop: pop suppressed, flush wins.
REQ-028 Latency: first instruction at if_valid one cycle after the ack that returns it; redirect-to-first-target-request one cycle (IDLE/ack case).
REQ-029 if_instr/if_pc hold value while if_valid && !if_ready.

Reset
REQ-030 rst_n=0 immediately: state IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, buffer empty, fetch PC=RESET_PC.
REQ-031 First request imem_addr=RESET_PC one cycle after rst_n deasserts; reset mid-request abandons it and a late ack is ignored per REQ-017.

Structure
REQ-032 Shared package dlx_fetch_pkg holds: state enum {IDLE,BUSY,DRAIN}, INSTR_W=32, ADDR_W=32, default RESET_PC.
REQ-033 Buffer is sub-module fetch_buffer (synchronous FIFO, depth BUF_DEPTH, push/pop/flush, count output); FSM and PC logic live in pc_fetch.

Verification
REQ-034 Reset release, ack every cycle, if_ready=1 -> addresses 0,4,8,C requested on consecutive cycles; if_pc follows one cycle behind acks.
REQ-035 if_ready=0, ack immediate -> exactly 2 requests (0,4), imem_req drops, if_valid stays 1 with if_pc=0 stable; raise if_ready -> fetch resumes at 8.
REQ-036 Request to 8 pending, ack delayed 3 cycles, take_branch target 32'h100 in cycle 1 -> imem_addr stays 8 until ack, word discarded, next imem_addr 32'h100, if_pc never 8.
REQ-037 take_branch target 32'h200 coincident with ack -> data discarded, next cycle imem_addr 32'h200; two pulses (0x300 then 0x400) during DRAIN -> next fetch 0x400.
REQ-038 Redirect to 32'hFFFF_FFFC, then ack -> next imem_addr 0; target 32'h103 -> imem_addr 32'h100.
REQ-039 rst_n low during BUSY, then ack while in reset -> imem_req=0 immediately, no push, fetch restarts at RESET_PC.
